iseq_arbiter: RTL and testbench

Shares the instruction-sequence dispatcher between two sequence sources: the host command path and the maintenance engine (periodic read / refresh calibration). It grants one source at a time write ownership of the shared instruction FIFOs. After that source finishes loading, the arbiter pulses `process_iseq`, tracks `dispatcher_busy` until the sequence drains, then releases ownership. It sits between the host/maintenance front-ends and `iseq_dispatcher`, and also drives the dispatcher's `periodic_read_lock`.

---
 rtl/iseq_arbiter_if.sv | 36 +++
 rtl/iseq_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_iseq_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iseq_arbiter_if.sv
// Signal bundle shared by the sequence sources, the arbiter and the instruction-sequence dispatcher.
// The arbiter uses the slave view; the surrounding logic (or a bench) uses the master view.
interface iseq_arbiter_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 host_req;
  logic                 host_gnt;
  logic                 host_load_done;
  logic                 host_seq_done;
  logic                 mnt_req;
  logic                 mnt_urgent;
  logic                 mnt_gnt;
  logic                 mnt_load_done;
  logic                 mnt_seq_done;
  logic                 fifo_wr_sel;
  logic                 process_iseq;
  logic                 dispatcher_busy;
  logic                 periodic_read_lock;
  logic                 start_err;
  logic                 err_clr;
  logic [CNT_WIDTH-1:0] seq_count;

  modport slave (
    input  host_req, host_load_done, mnt_req, mnt_urgent, mnt_load_done,
           dispatcher_busy, err_clr,
    output host_gnt, host_seq_done, mnt_gnt, mnt_seq_done, fifo_wr_sel,
           process_iseq, periodic_read_lock, start_err, seq_count
  );

  modport master (
    output host_req, host_load_done, mnt_req, mnt_urgent, mnt_load_done,
           dispatcher_busy, err_clr,
    input  host_gnt, host_seq_done, mnt_gnt, mnt_seq_done, fifo_wr_sel,
           process_iseq, periodic_read_lock, start_err, seq_count
  );
endinterface

// File: rtl/iseq_arbiter.sv
// Grants host or maintenance ownership of the instruction FIFOs, kicks the dispatcher and
// tracks the sequence until it drains. All outputs are registered from the next-state decode.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | arbitrate between host and maintenance requests
// S_LOAD      | owner writes the FIFOs; wait for its load_done or req drop
// S_KICK      | one-cycle process_iseq pulse to the dispatcher
// S_WAIT_BUSY | wait for dispatcher_busy, bounded by START_TIMEOUT
// S_RUN       | sequence dispatching; wait for dispatcher_busy to fall
// S_GAP       | GAP_CYCLES idle cycles, requests ignored
module iseq_arbiter #(
  parameter int GAP_CYCLES    = 4,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_WIDTH     = 16
) (
  input logic            clk,
  input logic            rst_n,
  iseq_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_KICK      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_RUN       = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  localparam logic [7:0] LP_TO_LAST  = 8'(START_TIMEOUT - 1);
  localparam logic [7:0] LP_GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_owner;
  logic                 w_owner_nxt;
  logic                 r_last;
  logic                 w_last_nxt;
  logic [7:0]           r_cnt;
  logic [7:0]           w_cnt_nxt;
  logic                 w_done;
  logic                 w_timeout;
  logic                 w_own_phase;
  logic                 w_own_req;
  logic                 w_own_load_done;

  logic                 r_host_gnt;
  logic                 r_mnt_gnt;
  logic                 r_host_seq_done;
  logic                 r_mnt_seq_done;
  logic                 r_process_iseq;
  logic                 r_start_err;
  logic [CNT_WIDTH-1:0] r_seq_count;

  // Only the current owner's handshake is observed; the other source's pulses are ignored.
  assign w_own_req       = r_owner ? bus.mnt_req       : bus.host_req;
  assign w_own_load_done = r_owner ? bus.mnt_load_done : bus.host_load_done;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_own_phase = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (bus.mnt_req && bus.mnt_urgent) begin
          w_owner_nxt = 1'b1;
          w_state_nxt = S_LOAD;
        end else if (bus.host_req && bus.mnt_req) begin
          w_owner_nxt = ~r_last;
          w_state_nxt = S_LOAD;
        end else if (bus.host_req) begin
          w_owner_nxt = 1'b0;
          w_state_nxt = S_LOAD;
        end else if (bus.mnt_req) begin
          w_owner_nxt = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        if (w_own_load_done) begin
          w_state_nxt = S_KICK;
        end else if (!w_own_req) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end
      end

      S_KICK: begin
        w_state_nxt = S_WAIT_BUSY;
        w_cnt_nxt   = '0;
      end

      S_WAIT_BUSY: begin
        if (bus.dispatcher_busy) begin
          w_state_nxt = S_RUN;
        end else if (r_cnt == LP_TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      S_RUN: begin
        if (!bus.dispatcher_busy) begin
          w_done      = 1'b1;
          w_last_nxt  = r_owner;
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end
      end

      S_GAP: begin
        if (r_cnt == LP_GAP_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_own_phase = (w_state_nxt == S_LOAD) || (w_state_nxt == S_KICK) ||
                  (w_state_nxt == S_WAIT_BUSY) || (w_state_nxt == S_RUN);
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_owner         <= 1'b0;
      r_last          <= 1'b1;
      r_cnt           <= '0;
      r_host_gnt      <= 1'b0;
      r_mnt_gnt       <= 1'b0;
      r_host_seq_done <= 1'b0;
      r_mnt_seq_done  <= 1'b0;
      r_process_iseq  <= 1'b0;
      r_start_err     <= 1'b0;
      r_seq_count     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_owner         <= w_owner_nxt;
      r_last          <= w_last_nxt;
      r_cnt           <= w_cnt_nxt;
      r_host_gnt      <= w_own_phase & ~w_owner_nxt;
      r_mnt_gnt       <= w_own_phase & w_owner_nxt;
      r_host_seq_done <= w_done & ~r_owner;
      r_mnt_seq_done  <= w_done & r_owner;
      r_process_iseq  <= (w_state_nxt == S_KICK);
      if (w_timeout) begin
        r_start_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_start_err <= 1'b0;
      end
      if (w_done) begin
        r_seq_count <= r_seq_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.host_gnt           = r_host_gnt;
  assign bus.mnt_gnt            = r_mnt_gnt;
  assign bus.host_seq_done      = r_host_seq_done;
  assign bus.mnt_seq_done       = r_mnt_seq_done;
  assign bus.fifo_wr_sel        = r_owner;
  assign bus.process_iseq       = r_process_iseq;
  assign bus.periodic_read_lock = r_mnt_gnt;
  assign bus.start_err          = r_start_err;
  assign bus.seq_count          = r_seq_count;

endmodule

// File: tb/tb_iseq_arbiter.sv
// Scoreboard bench for iseq_arbiter: the driver pushes expected grant/kick/done/error events
// from a rule-level model, and a negedge monitor pops them as the DUT produces them.
module tb_iseq_arbiter;
  localparam int GAP = 4;
  localparam int TO  = 16;
  localparam int CW  = 16;

  localparam int EV_GRANT = 0;
  localparam int EV_KICK  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERR   = 3;

  localparam int M_NORMAL  = 0;
  localparam int M_TIMEOUT = 1;
  localparam int M_ABORT   = 2;

  typedef struct {
    int kind;
    bit src;
    int cnt;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  iseq_arbiter_if #(.CNT_WIDTH(CW)) bus ();

  iseq_arbiter #(
    .GAP_CYCLES   (GAP),
    .START_TIMEOUT(TO),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int  n_checks    = 0;
  int  n_fail      = 0;
  ev_t sb[$];
  int  model_count = 0;
  bit  model_last  = 1'b1;
  int  disp_len    = 1;
  bit  disp_dead   = 1'b0;
  int  disp_cnt    = 0;
  int  cyc         = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Arbitration rule: urgent maintenance first, alternate on a tie, else the lone requester.
  function automatic bit model_winner(input bit h, input bit m, input bit u);
    if (m && u) return 1'b1;
    if (h && m) return !model_last;
    return m;
  endfunction

  // Dispatcher stand-in: goes busy the cycle after process_iseq for disp_len cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dispatcher_busy <= 1'b0;
      disp_cnt            <= 0;
    end else if (bus.process_iseq && !disp_dead) begin
      bus.dispatcher_busy <= 1'b1;
      disp_cnt            <= disp_len - 1;
    end else if (bus.dispatcher_busy) begin
      if (disp_cnt == 0) bus.dispatcher_busy <= 1'b0;
      else               disp_cnt <= disp_cnt - 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int kind, input bit src, input int cnt, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      chk(1'b0, {"unexpected_", name}, kind, -1);
    end else begin
      e = sb.pop_front();
      chk(e.kind == kind, {name, "_order"}, kind, e.kind);
      if (e.kind == kind) begin
        chk(e.src == src, {name, "_src"}, src, e.src);
        if (kind == EV_DONE || kind == EV_ERR) chk(e.cnt == cnt, {name, "_seq_count"}, cnt, e.cnt);
      end
    end
  endtask

  bit p_hg, p_mg, p_proc, p_hd, p_md, p_err, p_busy, p_sel, gap_valid;
  int fall_gnt_cyc, busy_fall_cyc, kick_cyc;

  always @(negedge clk) begin
    bit hr, mr, any_g;
    if (!rst_n) begin
      p_hg = 0; p_mg = 0; p_proc = 0; p_hd = 0; p_md = 0;
      p_err = 0; p_busy = 0; p_sel = 0; gap_valid = 0;
    end else begin
      hr    = bus.host_gnt && !p_hg;
      mr    = bus.mnt_gnt && !p_mg;
      any_g = bus.host_gnt || bus.mnt_gnt;
      chk(bus.periodic_read_lock == bus.mnt_gnt, "lock_eq_mnt_gnt", bus.periodic_read_lock, bus.mnt_gnt);
      chk(!(bus.host_gnt && bus.mnt_gnt), "gnt_exclusive", bus.host_gnt + bus.mnt_gnt, 1);
      if (bus.fifo_wr_sel != p_sel) chk(hr || mr, "sel_change_without_grant", bus.fifo_wr_sel, p_sel);
      if (hr || mr) begin
        if (gap_valid) chk(cyc - fall_gnt_cyc >= GAP + 1, "grant_gap", cyc - fall_gnt_cyc, GAP + 1);
        chk(bus.fifo_wr_sel == mr, "grant_sel", bus.fifo_wr_sel, mr);
        expect_ev(EV_GRANT, mr, 0, "grant");
      end
      if ((p_hg || p_mg) && !any_g) begin
        fall_gnt_cyc = cyc;
        gap_valid    = 1'b1;
      end
      if (bus.process_iseq && !p_proc) begin
        kick_cyc = cyc;
        expect_ev(EV_KICK, bus.fifo_wr_sel, 0, "kick");
      end
      if (p_proc) chk(!bus.process_iseq, "kick_width", bus.process_iseq, 0);
      if (p_hd) chk(!bus.host_seq_done, "host_done_width", bus.host_seq_done, 0);
      if (p_md) chk(!bus.mnt_seq_done, "mnt_done_width", bus.mnt_seq_done, 0);
      if ((bus.host_seq_done && !p_hd) || (bus.mnt_seq_done && !p_md)) begin
        chk(cyc - busy_fall_cyc == 1, "done_after_busy_fall", cyc - busy_fall_cyc, 1);
        chk(!any_g, "gnt_low_at_done", any_g, 0);
        expect_ev(EV_DONE, bus.mnt_seq_done, int'(bus.seq_count), "done");
      end
      if (bus.start_err && !p_err) begin
        chk(cyc - kick_cyc == TO + 1, "start_err_latency", cyc - kick_cyc, TO + 1);
        chk(!any_g, "gnt_low_at_err", any_g, 0);
        expect_ev(EV_ERR, bus.fifo_wr_sel, int'(bus.seq_count), "start_err");
      end
      if (p_busy && !bus.dispatcher_busy) busy_fall_cyc = cyc;
      p_hg   = bus.host_gnt;
      p_mg   = bus.mnt_gnt;
      p_proc = bus.process_iseq;
      p_hd   = bus.host_seq_done;
      p_md   = bus.mnt_seq_done;
      p_err  = bus.start_err;
      p_busy = bus.dispatcher_busy;
      p_sel  = bus.fifo_wr_sel;
    end
  end

  task automatic check_all_zero(input string tag);
    chk(bus.host_gnt == 0,           {tag, "_host_gnt"},      bus.host_gnt, 0);
    chk(bus.mnt_gnt == 0,            {tag, "_mnt_gnt"},       bus.mnt_gnt, 0);
    chk(bus.fifo_wr_sel == 0,        {tag, "_fifo_wr_sel"},   bus.fifo_wr_sel, 0);
    chk(bus.process_iseq == 0,       {tag, "_process_iseq"},  bus.process_iseq, 0);
    chk(bus.periodic_read_lock == 0, {tag, "_lock"},          bus.periodic_read_lock, 0);
    chk(bus.start_err == 0,          {tag, "_start_err"},     bus.start_err, 0);
    chk(bus.host_seq_done == 0,      {tag, "_host_seq_done"}, bus.host_seq_done, 0);
    chk(bus.mnt_seq_done == 0,       {tag, "_mnt_seq_done"},  bus.mnt_seq_done, 0);
    chk(bus.seq_count == 0,          {tag, "_seq_count"},     bus.seq_count, 0);
  endtask

  task automatic wait_empty(input int maxc, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk(sb.size() == 0, name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!(bus.host_gnt || bus.mnt_gnt) && n < 60) begin
      tick();
      n++;
    end
    chk(bus.host_gnt || bus.mnt_gnt, "grant_wait_cycles", n, 60);
  endtask

  task automatic run_seq(input bit h, input bit m, input bit u, input int load_dly,
                         input int run_len, input int mode, input bit stray, input bit clr_hold);
    bit  w;
    ev_t e;
    w = model_winner(h, m, u);
    e.kind = EV_GRANT; e.src = w; e.cnt = 0;
    sb.push_back(e);
    if (mode != M_ABORT) begin
      e.kind = EV_KICK;
      sb.push_back(e);
    end
    if (mode == M_NORMAL) begin
      model_count++;
      model_last = w;
      e.kind = EV_DONE; e.cnt = model_count % (1 << CW);
      sb.push_back(e);
    end else if (mode == M_TIMEOUT) begin
      e.kind = EV_ERR; e.cnt = model_count % (1 << CW);
      sb.push_back(e);
    end
    disp_len       = run_len;
    disp_dead      = (mode == M_TIMEOUT);
    bus.err_clr    = clr_hold;
    bus.host_req   = h;
    bus.mnt_req    = m;
    bus.mnt_urgent = u;
    wait_grant();
    repeat (load_dly) tick();
    if (stray) begin
      if (w) bus.host_load_done = 1'b1;
      else   bus.mnt_load_done  = 1'b1;
      tick();
      bus.host_load_done = 1'b0;
      bus.mnt_load_done  = 1'b0;
    end
    if (mode == M_ABORT) begin
      bus.host_req = 0; bus.mnt_req = 0; bus.mnt_urgent = 0;
      repeat (GAP + 4) tick();
    end else begin
      if (w) bus.mnt_load_done  = 1'b1;
      else   bus.host_load_done = 1'b1;
      tick();
      bus.host_load_done = 0; bus.mnt_load_done = 0;
      bus.host_req = 0; bus.mnt_req = 0; bus.mnt_urgent = 0;
    end
    wait_empty(run_len + TO + GAP + 40, "sequence_events_seen");
    if (mode == M_TIMEOUT) begin
      if (clr_hold) begin
        bus.err_clr = 1'b0;
        tick();
        chk(bus.start_err == 1, "err_set_beats_clr", bus.start_err, 1);
      end
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      chk(bus.start_err == 0, "err_clr_clears", bus.start_err, 0);
    end
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit  h, m, u, st, w;
    int  r, md;
    ev_t e;
    bus.host_req = 0; bus.host_load_done = 0; bus.mnt_req = 0; bus.mnt_urgent = 0;
    bus.mnt_load_done = 0; bus.err_clr = 0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;

    // Tie requests after reset: host, mnt, host, mnt.
    for (int i = 0; i < 4; i++) run_seq(1, 1, 0, 1, 3, M_NORMAL, 0, 0);
    run_seq(1, 0, 0, 3, 10, M_NORMAL, 0, 0);
    run_seq(0, 1, 0, 0, 2, M_NORMAL, 0, 0);
    run_seq(1, 1, 1, 0, 2, M_NORMAL, 0, 0);
    run_seq(1, 0, 0, 1, 5, M_TIMEOUT, 0, 0);
    run_seq(0, 1, 0, 1, 5, M_TIMEOUT, 0, 1);
    run_seq(1, 0, 0, 2, 5, M_ABORT, 1, 0);
    run_seq(1, 0, 0, 1, 3, M_NORMAL, 1, 0);

    for (int i = 0; i < 24; i++) begin
      h  = 1'($urandom_range(0, 1));
      m  = 1'($urandom_range(0, 1));
      if (!h && !m) h = 1'b1;
      u  = ($urandom_range(0, 3) == 0);
      r  = $urandom_range(0, 9);
      md = (r == 0) ? M_ABORT : (r == 1) ? M_TIMEOUT : M_NORMAL;
      st = ($urandom_range(0, 3) == 0);
      run_seq(h, m, u, $urandom_range(0, 4), $urandom_range(1, 12), md, st, 0);
    end

    // Reset in the middle of a maintenance-owned RUN.
    w = model_winner(0, 1, 0);
    e.kind = EV_GRANT; e.src = w; e.cnt = 0;
    sb.push_back(e);
    e.kind = EV_KICK;
    sb.push_back(e);
    disp_len = 40; disp_dead = 0;
    bus.mnt_req = 1'b1;
    wait_grant();
    bus.mnt_load_done = 1'b1;
    tick();
    bus.mnt_load_done = 1'b0;
    bus.mnt_req = 1'b0;
    r = 0;
    while (!bus.dispatcher_busy && r < 20) begin
      tick();
      r++;
    end
    repeat (3) tick();
    chk(bus.mnt_gnt == 1, "prereset_mnt_gnt", bus.mnt_gnt, 1);
    chk(bus.fifo_wr_sel == 1, "prereset_sel", bus.fifo_wr_sel, 1);
    chk(bus.periodic_read_lock == 1, "prereset_lock", bus.periodic_read_lock, 1);
    chk(sb.size() == 0, "prereset_events_seen", sb.size(), 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    sb.delete();
    model_count = 0;
    model_last  = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk(bus.seq_count == 0, "post_reset_seq_count", bus.seq_count, 0);
    run_seq(1, 1, 0, 0, 4, M_NORMAL, 0, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
